// File: rtl/wb_bus_arbiter_if.sv
// Handshake and broadcast-bus bundle between the execution units and the writeback arbiter.
// The slave modport is the arbiter side; master is the execution-unit / PRF side.
interface wb_bus_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 5
);
  logic              add_valid;
  logic [TAG_W-1:0]  add_tag;
  logic [DATA_W-1:0] add_data;
  logic              add_ready;
  logic              mul_valid;
  logic [TAG_W-1:0]  mul_tag;
  logic [DATA_W-1:0] mul_data;
  logic              mul_ready;
  logic              ls_valid;
  logic [TAG_W-1:0]  ls_tag;
  logic [DATA_W-1:0] ls_data;
  logic              ls_wb;
  logic              ls_ready;
  logic              bus0_valid;
  logic [TAG_W-1:0]  bus0_tag;
  logic [DATA_W-1:0] bus0_data;
  logic              bus1_valid;
  logic [TAG_W-1:0]  bus1_tag;
  logic [DATA_W-1:0] bus1_data;

  modport slave (
    input  add_valid, add_tag, add_data, mul_valid, mul_tag, mul_data,
           ls_valid, ls_tag, ls_data, ls_wb,
    output add_ready, mul_ready, ls_ready,
           bus0_valid, bus0_tag, bus0_data, bus1_valid, bus1_tag, bus1_data
  );

  modport master (
    output add_valid, add_tag, add_data, mul_valid, mul_tag, mul_data,
           ls_valid, ls_tag, ls_data, ls_wb,
    input  add_ready, mul_ready, ls_ready,
           bus0_valid, bus0_tag, bus0_data, bus1_valid, bus1_tag, bus1_data
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Writeback arbiter: three per-unit result FIFOs (ADD, MUL, LS) drained round-robin onto
// two registered broadcast buses feeding the PRF write ports and RS wakeup.
module wb_bus_arbiter #(
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_BUS    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  wb_bus_arbiter_if.slave wb
);
  localparam int NSRC = 3;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } res_t;

  res_t [NSRC-1:0]          in_res;
  logic [NSRC-1:0]          in_vld, in_keep, rdy, push, pop, ne;
  res_t                     mem_q [NSRC][FIFO_DEPTH];
  res_t                     head  [NSRC];
  logic [NSRC-1:0][PW-1:0]  wr_q, rd_q;
  logic [NSRC-1:0][CW-1:0]  cnt_q;
  logic [1:0]               rr_q, rr_d, last_src;
  logic [1:0]               g_vld;
  logic [1:0][1:0]          g_src;
  logic [2:0]               arb_idx;
  res_t [1:0]               bus_q;
  logic [1:0]               bus_vld_q;

  assign in_vld = {wb.ls_valid, wb.mul_valid, wb.add_valid};
  assign in_res = {{wb.ls_tag, wb.ls_data}, {wb.mul_tag, wb.mul_data}, {wb.add_tag, wb.add_data}};
  // P0 is hardwired and stores never write a register: take the handshake, drop the payload.
  assign in_keep = {(wb.ls_tag != '0) && wb.ls_wb, wb.mul_tag != '0, wb.add_tag != '0};

  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      rdy[s]  = rst && (cnt_q[s] < DEPTH_C);
      push[s] = in_vld[s] && rdy[s] && in_keep[s] && !flush;
      ne[s]   = (cnt_q[s] != '0);
      head[s] = mem_q[s][rd_q[s]];
    end
  end

  assign wb.add_ready = rdy[0];
  assign wb.mul_ready = rdy[1];
  assign wb.ls_ready  = rdy[2];

  // Cyclic scan from rr_q: first non-empty head to bus0, second to bus1.
  always_comb begin
    g_vld   = '0;
    g_src   = '0;
    arb_idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      arb_idx = {1'b0, rr_q} + 3'(k);
      if (arb_idx >= 3'(NSRC)) arb_idx = arb_idx - 3'(NSRC);
      if (ne[arb_idx[1:0]]) begin
        if (!g_vld[0]) begin
          g_vld[0] = 1'b1;
          g_src[0] = arb_idx[1:0];
        end else if (!g_vld[1]) begin
          g_vld[1] = 1'b1;
          g_src[1] = arb_idx[1:0];
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NSRC; s++)
      pop[s] = (g_vld[0] && g_src[0] == 2'(s)) || (g_vld[1] && g_src[1] == 2'(s));
    last_src = g_vld[1] ? g_src[1] : g_src[0];
    rr_d     = rr_q;
    if (g_vld[0]) rr_d = (last_src == 2'd2) ? 2'd0 : last_src + 2'd1;
  end

  // Storage needs no reset: validity is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++)
      if (push[s]) mem_q[s][wr_q[s]] <= in_res[s];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      rr_q      <= '0;
      bus_q     <= '0;
      bus_vld_q <= '0;
    end else if (flush) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      rr_q      <= '0;
      bus_vld_q <= '0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (push[s]) wr_q[s] <= wr_q[s] + PW'(1);
        if (pop[s])  rd_q[s] <= rd_q[s] + PW'(1);
        cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
      rr_q      <= rr_d;
      bus_vld_q <= g_vld;
      if (g_vld[0]) bus_q[0] <= head[g_src[0]];
      if (g_vld[1]) bus_q[1] <= head[g_src[1]];
    end
  end

  assign wb.bus0_valid = bus_vld_q[0];
  assign wb.bus0_tag   = bus_q[0].tag;
  assign wb.bus0_data  = bus_q[0].data;
  assign wb.bus1_valid = bus_vld_q[1];
  assign wb.bus1_tag   = bus_q[1].tag;
  assign wb.bus1_data  = bus_q[1].data;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: accepted results are queued per source and a
// negedge monitor matches every broadcast against the queue heads.
module tb_wb_bus_arbiter;
  logic clk, rst, flush;
  int checks = 0, errors = 0;
  int gcnt [3];
  bit sawnr [3];

  typedef struct {
    logic [4:0]  tag;
    logic [15:0] data;
  } exp_t;
  exp_t sbq [3][$];

  wb_bus_arbiter_if #(.DATA_W(16), .TAG_W(5)) wbi ();

  wb_bus_arbiter #(.DATA_W(16), .TAG_W(5), .FIFO_DEPTH(2), .NUM_BUS(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb(wbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Expected pushes: accepted handshakes with a real destination register.
  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      for (int s = 0; s < 3; s++) sbq[s].delete();
    end else begin
      if (wbi.add_valid && wbi.add_ready && wbi.add_tag != 0)
        sbq[0].push_back('{wbi.add_tag, wbi.add_data});
      if (wbi.mul_valid && wbi.mul_ready && wbi.mul_tag != 0)
        sbq[1].push_back('{wbi.mul_tag, wbi.mul_data});
      if (wbi.ls_valid && wbi.ls_ready && wbi.ls_wb && wbi.ls_tag != 0)
        sbq[2].push_back('{wbi.ls_tag, wbi.ls_data});
    end
  end

  task automatic chk_bus(input int b, input logic [4:0] t, input logic [15:0] d);
    int found;
    found = -1;
    checks++;
    for (int s = 0; s < 3; s++)
      if (found < 0 && sbq[s].size() > 0 && sbq[s][0].tag == t && sbq[s][0].data == d) found = s;
    if (found < 0) begin
      errors++;
      $display("FAIL bus%0d_unexpected got tag=%0d data=%h expected=a queued head", b, t, d);
    end else begin
      void'(sbq[found].pop_front());
      gcnt[found]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (wbi.bus0_valid) chk_bus(0, wbi.bus0_tag, wbi.bus0_data);
      if (wbi.bus1_valid) chk_bus(1, wbi.bus1_tag, wbi.bus1_data);
      if (!wbi.add_ready) sawnr[0] = 1'b1;
      if (!wbi.mul_ready) sawnr[1] = 1'b1;
      if (!wbi.ls_ready)  sawnr[2] = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int s, input logic v, input logic [4:0] t, input logic [15:0] d);
    case (s)
      0: begin wbi.add_valid = v; wbi.add_tag = t; wbi.add_data = d; end
      1: begin wbi.mul_valid = v; wbi.mul_tag = t; wbi.mul_data = d; end
      default: begin wbi.ls_valid = v; wbi.ls_tag = t; wbi.ls_data = d; end
    endcase
  endtask

  task automatic idle();
    for (int s = 0; s < 3; s++) drv(s, 1'b0, 5'd0, 16'h0);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_bus0_valid"}, 32'(wbi.bus0_valid), 32'd0);
    chk({nm, "_bus1_valid"}, 32'(wbi.bus1_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; wbi.ls_wb = 1'b1;
    idle();
    #3;
    chk_quiet("reset");
    chk("reset_readies", {29'd0, wbi.ls_ready, wbi.mul_ready, wbi.add_ready}, 32'd0);
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("post_reset_readies", {29'd0, wbi.ls_ready, wbi.mul_ready, wbi.add_ready}, 32'h7);

    // single ADD push, 1-cycle visible latency
    drv(0, 1'b1, 5'd3, 16'h1234);
    cyc(); idle();
    chk_quiet("t1_no_bypass");
    cyc();
    chk("t1_bus0_valid", 32'(wbi.bus0_valid), 32'd1);
    chk("t1_bus0_tag",   32'(wbi.bus0_tag),   32'd3);
    chk("t1_bus0_data",  32'(wbi.bus0_data),  32'h1234);
    chk("t1_bus1_valid", 32'(wbi.bus1_valid), 32'd0);
    cyc();
    chk_quiet("t1_after");

    // three simultaneous pushes from rr_ptr = 0
    flush = 1'b1; cyc(); flush = 1'b0;
    drv(0, 1'b1, 5'd1, 16'h00A1); drv(1, 1'b1, 5'd2, 16'h00A2); drv(2, 1'b1, 5'd3, 16'h00A3);
    cyc(); idle();
    cyc();
    chk("t2_c1_bus0_tag", {31'd0, wbi.bus0_valid}, 32'd1);
    chk("t2_c1_bus0_tag", 32'(wbi.bus0_tag), 32'd1);
    chk("t2_c1_bus1_tag", {26'd0, wbi.bus1_valid, wbi.bus1_tag}, {26'd0, 1'b1, 5'd2});
    drv(0, 1'b1, 5'd6, 16'h00B6); drv(1, 1'b1, 5'd4, 16'h00B4);
    cyc(); idle();
    chk("t2_c2_bus0_tag", {26'd0, wbi.bus0_valid, wbi.bus0_tag}, {26'd0, 1'b1, 5'd3});
    chk("t2_c2_bus1_valid", 32'(wbi.bus1_valid), 32'd0);
    cyc();
    chk("t2_rr_back_bus0", {26'd0, wbi.bus0_valid, wbi.bus0_tag}, {26'd0, 1'b1, 5'd6});
    chk("t2_rr_back_bus1", {26'd0, wbi.bus1_valid, wbi.bus1_tag}, {26'd0, 1'b1, 5'd4});
    cyc(); cyc();

    // full load for 12 cycles
    for (int s = 0; s < 3; s++) begin gcnt[s] = 0; sawnr[s] = 1'b0; end
    for (int c = 0; c < 12; c++) begin
      for (int s = 0; s < 3; s++)
        drv(s, 1'b1, 5'((c * 3 + s) % 31 + 1), 16'h3000 + 16'(c * 16 + s));
      cyc();
    end
    idle();
    @(posedge clk); @(negedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("t3_grants_src%0d", s), 32'(gcnt[s]), 32'd8);
      chk($sformatf("t3_ready_dropped_src%0d", s), 32'(sawnr[s]), 32'd1);
    end
    repeat (6) cyc();
    for (int s = 0; s < 3; s++)
      chk($sformatf("t3_drained_src%0d", s), 32'(sbq[s].size()), 32'd0);

    // discarded entries: store and tag 0
    wbi.ls_wb = 1'b0;
    drv(2, 1'b1, 5'd5, 16'h0055); drv(0, 1'b1, 5'd0, 16'h0066);
    chk("t4_readies", {30'd0, wbi.ls_ready, wbi.add_ready}, 32'h3);
    cyc(); idle(); wbi.ls_wb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_quiet($sformatf("t4_quiet%0d", i));
      cyc();
    end

    // flush with queued entries, inputs in the flush cycle dropped
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 3; s++) drv(s, 1'b1, 5'(10 + c * 3 + s), 16'h5000 + 16'(c * 16 + s));
      cyc();
    end
    for (int s = 0; s < 3; s++) drv(s, 1'b1, 5'(20 + s), 16'h5F00 + 16'(s));
    flush = 1'b1;
    cyc(); flush = 1'b0; idle();
    chk_quiet("t5_flush");
    chk("t5_readies", {29'd0, wbi.ls_ready, wbi.mul_ready, wbi.add_ready}, 32'h7);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_quiet($sformatf("t5_quiet%0d", i));
    end

    // asynchronous reset mid-burst
    for (int s = 0; s < 3; s++) drv(s, 1'b1, 5'(25 + s), 16'h6000 + 16'(s));
    cyc(); cyc();
    #2 rst = 1'b0;
    #1;
    chk_quiet("t6_rst_async");
    chk("t6_rst_readies", {29'd0, wbi.ls_ready, wbi.mul_ready, wbi.add_ready}, 32'd0);
    idle();
    cyc();
    #2 rst = 1'b1;
    drv(0, 1'b1, 5'd7, 16'hBEEF);
    cyc(); idle();
    cyc();
    chk("t6_bus0", {10'd0, wbi.bus0_valid, wbi.bus0_tag, wbi.bus0_data}, {10'd0, 1'b1, 5'd7, 16'hBEEF});
    chk("t6_bus1_valid", 32'(wbi.bus1_valid), 32'd0);
    repeat (3) cyc();
    chk_quiet("t6_no_stale");
    for (int s = 0; s < 3; s++)
      chk($sformatf("final_empty_src%0d", s), 32'(sbq[s].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
